multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-FSM control unit for the multi-cycle datapath; successor to the single-cycle combinational decoder.
- Sequences each instruction through IF/ID/EX/MEM/WB steps and drives per-step datapath controls.
- Parametrised opcode/ALUOp width, optional memory wait-state handshake, illegal-opcode flag, retired-instruction counter.

Parameters:
- OP_W, 6, opcode width
- ALUOP_W, 3, ALU operation select width
- USE_MEM_READY, 1, 1 = IF/MEM_RD/MEM_WR wait for mem_ready; 0 = mem_ready ignored (treated as 1)
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op  in  OP_W  opcode field of instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC load enable (includes beq-taken)
- ir_write  out  1  instruction register load
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination: 0 = rt, 1 = rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = rs data
- alu_src_b  out  2  00 = rt data, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  out  ALUOP_W  ALU function
- pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- illegal_op  out  1  one-cycle pulse on unknown opcode
- halted  out  1  FSM in HALT
- state_o  out  4  current state (debug)
- instr_retired  out  CNT_W  retired-instruction count

Behaviour:
- Opcodes: ADD 000000, ADDI 001000, LW 100011, SW 101011, BEQ 000100, J 000010, HALT 111111 (zero-extended when OP_W > 6).
- States: INIT, IF, ID, EX_R, EX_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BR, JMP, HALT.
- Reset (async, rst_n low): state = INIT, instr_retired = 0. Every control output is 0 in INIT. INIT -> IF on the next clk.
- IF: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD, pc_source = 00. ir_write and pc_write = mem_ready (gated). Stays in IF while mem_ready = 0; otherwise -> ID.
- ID: alu_src_a = 0, alu_src_b = 11, alu_op = ADD (precompute branch target). Next state by op:
  - ADD -> EX_R; ADDI -> EX_I; LW/SW -> MEM_ADDR
  - BEQ -> BR; J -> JMP; HALT -> HALT
  - other -> IF, with illegal_op = 1 for this cycle only
- EX_R: alu_src_a = 1, alu_src_b = 00, alu_op = ADD -> WB_R.
- EX_I and MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. EX_I -> WB_I; MEM_ADDR -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read = 1, i_or_d = 1. Waits for mem_ready, then -> WB_MEM.
- MEM_WR: mem_write = 1, i_or_d = 1. Waits for mem_ready, then -> IF.
- WB_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
- WB_I: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
- WB_MEM: reg_write = 1, reg_dst = 0, mem_to_reg = 1. All three WB states -> IF.
- BR: alu_src_a = 1, alu_src_b = 00, alu_op = SUB, pc_source = 01, pc_write = zero -> IF.
- JMP: pc_source = 10, pc_write = 1 -> IF.
- HALT: halted = 1, all other controls 0. Self-loop; only reset exits.
- Cycle counts with mem_ready held 1: ADD/ADDI/SW 4, LW 5, BEQ/J 3. Each wait cycle adds 1.
- instr_retired: +1 on the final cycle of each legal non-HALT instruction. Final cycles are WB_R, WB_I, WB_MEM, BR, JMP, and MEM_WR with mem_ready = 1.
  - Wraps modulo 2^CNT_W.
  - Illegal opcodes and HALT do not count.
- Outputs are pure decode of state, plus the zero / mem_ready gating above. Unused outputs are 0 in every state.
- Reset asserted mid-instruction: immediate return to INIT; no partial strobes after reset assertion.

Decomposition:
- Shared package holds:
  - opcode constants and ALU op constants (ADD = 000, SUB = 001)
  - state encoding typedef
  - alu_src_b and pc_source encodings
- One natural sub-module: mcu_next_state, combinational next-state logic from state, op and mem_ready.

Test Plan:
- Reset, then release, with op = ADD and mem_ready = 1 -> INIT, IF, ID, EX_R, WB_R, IF. reg_write = 1 and reg_dst = 1 only in WB_R. instr_retired = 1.
- LW with USE_MEM_READY = 1, mem_ready low for 2 cycles in IF and 3 in MEM_RD -> total 10 cycles. ir_write pulses exactly once.
- BEQ with zero = 1, then BEQ with zero = 0 -> pc_write = 1 in BR with pc_source = 01 in the first case; pc_write = 0 in BR in the second.
- op = 110011 -> illegal_op high exactly 1 cycle in ID, FSM back to IF, instr_retired unchanged.
- op = HALT -> halted = 1 held for 20+ cycles with pc_write = 0. rst_n pulse returns FSM to INIT and clears the counter.
- CNT_W = 2, retire 5 instructions -> instr_retired reads 1 (wrap). rst_n low during MEM_WR -> mem_write drops asynchronously.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared encodings for the multi-cycle control unit
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IF       = 4'd1,
        S_ID       = 4'd2,
        S_EX_R     = 4'd3,
        S_EX_I     = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_R     = 4'd8,
        S_WB_I     = 4'd9,
        S_WB_MEM   = 4'd10,
        S_BR       = 4'd11,
        S_JMP      = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control bus between the control unit and the datapath
interface multicycle_control_unit_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
);
    logic [OP_W-1:0]    op;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               ir_write;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_source;
    logic               illegal_op;
    logic               halted;
    logic [3:0]         state_o;
    logic [CNT_W-1:0]   instr_retired;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op, halted, state_o, instr_retired
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal_op, halted, state_o, instr_retired
    );
endinterface

// File: rtl/multicycle_control_unit_next_state.sv
// rtl/multicycle_control_unit_next_state.sv - combinational next-state and illegal-opcode decode
module mcu_next_state
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  state_t          state_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            mem_ok_i,
    output state_t          state_d_o,
    output logic            illegal_o
);
    // Opcodes are zero-extended when the field is wider than six bits.
    localparam logic [OP_W-1:0] L_ADD  = OP_W'(OP_ADD);
    localparam logic [OP_W-1:0] L_ADDI = OP_W'(OP_ADDI);
    localparam logic [OP_W-1:0] L_LW   = OP_W'(OP_LW);
    localparam logic [OP_W-1:0] L_SW   = OP_W'(OP_SW);
    localparam logic [OP_W-1:0] L_BEQ  = OP_W'(OP_BEQ);
    localparam logic [OP_W-1:0] L_J    = OP_W'(OP_J);
    localparam logic [OP_W-1:0] L_HALT = OP_W'(OP_HALT);

    always_comb begin
        state_d_o = state_i;
        illegal_o = 1'b0;
        case (state_i)
            S_INIT:     state_d_o = S_IF;
            S_IF:       if (mem_ok_i) state_d_o = S_ID;
            S_ID: begin
                if (op_i == L_ADD)                     state_d_o = S_EX_R;
                else if (op_i == L_ADDI)               state_d_o = S_EX_I;
                else if (op_i == L_LW || op_i == L_SW) state_d_o = S_MEM_ADDR;
                else if (op_i == L_BEQ)                state_d_o = S_BR;
                else if (op_i == L_J)                  state_d_o = S_JMP;
                else if (op_i == L_HALT)               state_d_o = S_HALT;
                else begin
                    state_d_o = S_IF;
                    illegal_o = 1'b1;
                end
            end
            S_EX_R:     state_d_o = S_WB_R;
            S_EX_I:     state_d_o = S_WB_I;
            // MEM_ADDR is only reachable from LW or SW.
            S_MEM_ADDR: state_d_o = (op_i == L_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ok_i) state_d_o = S_WB_MEM;
            S_MEM_WR:   if (mem_ok_i) state_d_o = S_IF;
            S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP: state_d_o = S_IF;
            S_HALT:     state_d_o = S_HALT;
            default:    state_d_o = S_INIT;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore control FSM for the multi-cycle datapath
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int ALUOP_W       = 3,
    parameter int USE_MEM_READY = 1,
    parameter int CNT_W         = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_unit_if.master   bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_ok;
    logic             illegal;
    logic             retire;

    logic               pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic               mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
    logic [1:0]         alu_src_b, pc_source;
    logic [ALUOP_W-1:0] alu_op;

    assign mem_ok = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;

    mcu_next_state #(.OP_W(OP_W)) u_next_state (
        .state_i   (state_q),
        .op_i      (bus.op),
        .mem_ok_i  (mem_ok),
        .state_d_o (state_d),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        case (state_q)
            S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP: retire = 1'b1;
            S_MEM_WR:                              retire = mem_ok;
            default:                               retire = 1'b0;
        endcase
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALUOP_W'(ALU_ADD);
        pc_source  = PCSRC_ALU;
        halted     = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
            end
            S_ID:       alu_src_b = SRCB_IMM_SH2;
            S_EX_R:     alu_src_a = 1'b1;
            S_EX_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_WB_I:     reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(ALU_SUB);
                pc_source = PCSRC_ALUOUT;
                pc_write  = bus.zero;
            end
            S_JMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            S_HALT:     halted = 1'b1;
            default:    ;
        endcase
    end

    assign bus.pc_write      = pc_write;
    assign bus.ir_write      = ir_write;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_dst       = reg_dst;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.pc_source     = pc_source;
    assign bus.illegal_op    = illegal;
    assign bus.halted        = halted;
    assign bus.state_o       = state_q;
    assign bus.instr_retired = cnt_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.OP_W(6), .ALUOP_W(3), .CNT_W(16)) bus  ();
    multicycle_control_unit_if #(.OP_W(6), .ALUOP_W(3), .CNT_W(2))  bus2 ();

    assign bus2.op        = bus.op;
    assign bus2.zero      = bus.zero;
    assign bus2.mem_ready = bus.mem_ready;

    multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .USE_MEM_READY(1), .CNT_W(16)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus.master)
    );
    multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .USE_MEM_READY(1), .CNT_W(2)) dut_w2 (
        .clk (clk), .rst_n (rst_n), .bus (bus2.master)
    );

    typedef struct packed {
        logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op, halted;
    } ctrl_t;

    typedef struct {
        state_t      s;
        ctrl_t       c;
        int unsigned cnt;
    } exp_t;

    exp_t        expq[$];
    int unsigned model_cnt;
    int          checks = 0;
    int          errors = 0;
    int          ir_cnt = 0, rd_cnt = 0, ill_cnt = 0;
    ctrl_t       dut_c;

    assign dut_c = {bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write,
                    bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op, bus.halted};

    // What each step must drive, written straight from the control table.
    function automatic ctrl_t expect_ctrl(state_t s, logic [5:0] op, logic z, logic mr);
        ctrl_t c = '0;
        case (s)
            S_IF:       begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_write = mr; c.ir_write = mr; end
            S_ID:       begin
                c.alu_src_b  = 2'b11;
                c.illegal_op = !(op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011,
                                            6'b000100, 6'b000010, 6'b111111});
            end
            S_EX_R:     c.alu_src_a = 1;
            S_EX_I, S_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEM_RD:   begin c.mem_read = 1; c.i_or_d = 1; end
            S_MEM_WR:   begin c.mem_write = 1; c.i_or_d = 1; end
            S_WB_R:     begin c.reg_write = 1; c.reg_dst = 1; end
            S_WB_I:     c.reg_write = 1;
            S_WB_MEM:   begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_BR:       begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_source = 2'b01; c.pc_write = z; end
            S_JMP:      begin c.pc_source = 2'b10; c.pc_write = 1; end
            S_HALT:     c.halted = 1;
            default:    ;
        endcase
        return c;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        ir_cnt  += int'(bus.ir_write);
        rd_cnt  += int'(bus.mem_read);
        ill_cnt += int'(bus.illegal_op);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks += 4;
            if (dut_c !== e.c) begin
                errors++;
                $display("FAIL ctrl t=%0t step=%s got=%b exp=%b", $time, e.s.name(), dut_c, e.c);
            end
            if (bus.state_o !== 4'(e.s)) begin
                errors++;
                $display("FAIL state t=%0t got=%0d exp=%0d", $time, bus.state_o, e.s);
            end
            if (bus.instr_retired !== e.cnt[15:0]) begin
                errors++;
                $display("FAIL retired t=%0t got=%0d exp=%0d", $time, bus.instr_retired, e.cnt[15:0]);
            end
            if (bus2.instr_retired !== e.cnt[1:0]) begin
                errors++;
                $display("FAIL retired_w2 t=%0t got=%0d exp=%0d", $time, bus2.instr_retired, e.cnt[1:0]);
            end
        end
    end

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock cycle in step s; called at posedge+1, returns at next posedge+1.
    task automatic cyc(state_t s, logic z, logic mr);
        exp_t e;
        bus.zero      = z;
        bus.mem_ready = mr;
        e.s   = s;
        e.c   = expect_ctrl(s, bus.op, z, mr);
        e.cnt = model_cnt;
        expq.push_back(e);
        if (s inside {S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP} || (s == S_MEM_WR && mr))
            model_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(logic [5:0] op, logic z, int if_w, int mem_w);
        bus.op = op;
        repeat (if_w) cyc(S_IF, z, 1'b0);
        cyc(S_IF, z, 1'b1);
        cyc(S_ID, z, 1'($urandom));
        case (op)
            6'b000000: begin cyc(S_EX_R, z, 1'b1); cyc(S_WB_R, z, 1'b1); end
            6'b001000: begin cyc(S_EX_I, z, 1'b1); cyc(S_WB_I, z, 1'b1); end
            6'b100011: begin
                cyc(S_MEM_ADDR, z, 1'b1);
                repeat (mem_w) cyc(S_MEM_RD, z, 1'b0);
                cyc(S_MEM_RD, z, 1'b1);
                cyc(S_WB_MEM, z, 1'b1);
            end
            6'b101011: begin
                cyc(S_MEM_ADDR, z, 1'b1);
                repeat (mem_w) cyc(S_MEM_WR, z, 1'b0);
                cyc(S_MEM_WR, z, 1'b1);
            end
            6'b000100: cyc(S_BR, z, 1'b1);
            6'b000010: cyc(S_JMP, z, 1'b1);
            6'b111111: repeat (22) cyc(S_HALT, 1'($urandom), 1'($urandom));
            default:   ;
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(S_INIT, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.op        = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        chk("reset_state", int'(bus.state_o), int'(S_INIT));
        chk("reset_ctrl_zero", int'(dut_c), 0);
        do_reset();

        run_instr(6'b000000, 1'b0, 0, 0);
        chk("retired_after_add", int'(bus.instr_retired), 1);

        ir_cnt = 0; rd_cnt = 0;
        run_instr(6'b100011, 1'b0, 2, 3);
        chk("lw_ir_write_pulses", ir_cnt, 1);
        chk("lw_mem_read_cycles", rd_cnt, 7);
        chk("retired_after_lw", int'(bus.instr_retired), 2);

        run_instr(6'b000100, 1'b1, 0, 0);
        run_instr(6'b000100, 1'b0, 0, 0);
        chk("retired_after_beq", int'(bus.instr_retired), 4);

        ill_cnt = 0;
        run_instr(6'b110011, 1'b0, 0, 0);
        chk("illegal_pulses", ill_cnt, 1);
        chk("illegal_back_to_if", int'(bus.state_o), int'(S_IF));
        chk("retired_after_illegal", int'(bus.instr_retired), 4);

        run_instr(6'b001000, 1'b0, 1, 0);
        chk("retired_w2_wrap", int'(bus2.instr_retired), 1);

        run_instr(6'b101011, 1'b0, 0, 1);
        run_instr(6'b000010, 1'b0, 0, 0);
        chk("retired_after_j", int'(bus.instr_retired), 7);

        run_instr(6'b111111, 1'b0, 0, 0);
        chk("halt_held", int'(bus.halted), 1);
        rst_n = 1'b0;
        #1;
        chk("halt_reset_state", int'(bus.state_o), int'(S_INIT));
        chk("halt_reset_cnt", int'(bus.instr_retired), 0);
        chk("halt_reset_halted", int'(bus.halted), 0);
        do_reset();

        bus.op = 6'b101011;
        cyc(S_IF, 1'b0, 1'b1);
        cyc(S_ID, 1'b0, 1'b1);
        cyc(S_MEM_ADDR, 1'b0, 1'b1);
        bus.mem_ready = 1'b0;
        #1;
        chk("memwr_strobe_before_reset", int'(bus.mem_write), 1);
        rst_n = 1'b0;
        #1;
        chk("memwr_async_drop", int'(bus.mem_write), 0);
        chk("memwr_async_i_or_d", int'(bus.i_or_d), 0);
        chk("memwr_async_state", int'(bus.state_o), int'(S_INIT));
        do_reset();

        run_instr(6'b000000, 1'b0, 0, 0);
        chk("retired_after_recovery", int'(bus.instr_retired), 1);

        @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
